// File: rtl/buyruk_getir_arabirimi_pkg.sv
// ----------------------------------------------------------------------------
// buyruk_getir_arabirimi_pkg
//   Shared widths and types for the instruction-fetch interface slice.
//   ADRES_BIT / L1_BLOK_BIT are the system-wide address and L1 block widths;
//   GETIR_KUYRUK_DERINLIK is the default response-queue depth (and therefore
//   the default number of outstanding fetches).
//   Optional feature macro used by the slice: GETIR_TEMIZLE_EN (flush support).
// ----------------------------------------------------------------------------
package buyruk_getir_arabirimi_pkg;

    localparam int unsigned ADRES_BIT             = 32;
    localparam int unsigned L1_BLOK_BIT           = 32;
    localparam int unsigned GETIR_KUYRUK_DERINLIK = 4;

    typedef logic [ADRES_BIT-1:0]   adres_t;
    typedef logic [L1_BLOK_BIT-1:0] blok_t;

endpackage

// File: rtl/buyruk_getir_arabirimi_yanit_kuyrugu.sv
// ----------------------------------------------------------------------------
// yanit_kuyrugu
//   Circular response FIFO. Head entry is read straight from registered
//   storage, so an entry written in cycle N is visible from cycle N+1 and the
//   head stays stable until it is popped.
//   Optional feature macro of the slice: GETIR_TEMIZLE_EN (drives temizle_i
//   from the top; tied low otherwise).
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       synchronous active-low reset (empties the queue)
//   temizle_i    synchronous clear (empties the queue)
//   yaz_i        push request; accepted when not full or when popping
//   yaz_veri_i   push data
//   oku_i        pop request; ignored when empty
//   bas_veri_o   head entry
//   bos_o        queue empty
//   dolu_o       queue full
//   doluluk_o    occupancy, 0..DERINLIK
// ----------------------------------------------------------------------------
module yanit_kuyrugu
    import buyruk_getir_arabirimi_pkg::*;
#(
    parameter int unsigned DERINLIK = GETIR_KUYRUK_DERINLIK,
    parameter int unsigned VERI_BIT = L1_BLOK_BIT
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       temizle_i,
    input  logic                       yaz_i,
    input  logic [VERI_BIT-1:0]        yaz_veri_i,
    input  logic                       oku_i,
    output logic [VERI_BIT-1:0]        bas_veri_o,
    output logic                       bos_o,
    output logic                       dolu_o,
    output logic [$clog2(DERINLIK):0]  doluluk_o
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned SW = PW + 1;
    localparam logic [SW-1:0] DERINLIK_S = SW'(DERINLIK);

    logic [VERI_BIT-1:0] bellek_q [DERINLIK];
    logic [PW-1:0]       yaz_ptr_q;
    logic [PW-1:0]       oku_ptr_q;
    logic [SW-1:0]       sayi_q;
    logic [SW-1:0]       sayi_d;
    logic                itme;
    logic                cekme;

    assign bos_o      = (sayi_q == '0);
    assign dolu_o     = (sayi_q == DERINLIK_S);
    assign cekme      = oku_i & ~bos_o;
    // A push on a full queue is legal when the head leaves in the same cycle.
    assign itme       = yaz_i & (~dolu_o | cekme);
    assign bas_veri_o = bellek_q[oku_ptr_q];
    assign doluluk_o  = sayi_q;

    always_comb begin
        sayi_d = sayi_q + SW'(itme) - SW'(cekme);
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || temizle_i) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayi_q    <= '0;
        end else begin
            if (itme) begin
                yaz_ptr_q <= yaz_ptr_q + PW'(1);
            end
            if (cekme) begin
                oku_ptr_q <= oku_ptr_q + PW'(1);
            end
            sayi_q <= sayi_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (itme) begin
            bellek_q[yaz_ptr_q] <= yaz_veri_i;
        end
    end

endmodule

// File: rtl/buyruk_getir_arabirimi.sv
// ----------------------------------------------------------------------------
// buyruk_getir_arabirimi
//   Credit-based instruction-fetch interface between the core and instruction
//   memory. A request is forwarded only while fewer than KUYRUK_DERINLIK
//   fetches are outstanding (in flight or queued), so every memory response is
//   guaranteed a queue slot. Responses are returned to the core in request
//   order through yanit_kuyrugu with one cycle of latency.
//   Optional flush: define GETIR_TEMIZLE_EN to add temizle_i, which empties
//   the queue and discards the responses of fetches still in flight.
//
// Ports
//   clk_i                  clock, rising edge
//   rstn_i                 synchronous active-low reset
//   cek_istek_adres_i      core fetch address
//   cek_istek_gecerli_i    core request valid
//   cek_istek_hazir_o      core request accepted (with valid)
//   cek_yanit_veri_o       instruction block to core
//   cek_yanit_gecerli_o    response valid to core
//   cek_yanit_hazir_i      core consumes response
//   bel_istek_adres_o      address to instruction memory
//   bel_istek_gecerli_o    memory request valid
//   bel_istek_hazir_i      memory request ready
//   bel_yanit_veri_i       in-order memory response data
//   bel_yanit_gecerli_i    memory response valid (no backpressure)
//   temizle_i              flush pulse (GETIR_TEMIZLE_EN only)
// ----------------------------------------------------------------------------
module buyruk_getir_arabirimi
    import buyruk_getir_arabirimi_pkg::*;
#(
    parameter int unsigned KUYRUK_DERINLIK = GETIR_KUYRUK_DERINLIK
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [ADRES_BIT-1:0]    cek_istek_adres_i,
    input  logic                    cek_istek_gecerli_i,
    output logic                    cek_istek_hazir_o,
    output logic [L1_BLOK_BIT-1:0]  cek_yanit_veri_o,
    output logic                    cek_yanit_gecerli_o,
    input  logic                    cek_yanit_hazir_i,
    output logic [ADRES_BIT-1:0]    bel_istek_adres_o,
    output logic                    bel_istek_gecerli_o,
    input  logic                    bel_istek_hazir_i,
    input  logic [L1_BLOK_BIT-1:0]  bel_yanit_veri_i,
`ifdef GETIR_TEMIZLE_EN
    input  logic                    temizle_i,
`endif
    input  logic                    bel_yanit_gecerli_i
);

    localparam int unsigned SW = $clog2(KUYRUK_DERINLIK) + 1;
    localparam logic [SW-1:0] DERINLIK_S = SW'(KUYRUK_DERINLIK);

    logic [SW-1:0] bekleyen_q;
    logic [SW-1:0] bekleyen_d;
    logic [SW-1:0] doluluk;
    logic          kuyruk_bos;
    logic          kuyruk_dolu;
    blok_t         bas_veri;
    logic          kredi_var;
    logic          ucusta_var;
    logic          temizle;
    logic          istek_el;
    logic          yanit_el;
    logic          varis;
    logic          yanit_yaz;

`ifdef GETIR_TEMIZLE_EN
    logic [SW-1:0] atilacak_q;
    logic [SW-1:0] atilacak_d;
    logic          at;

    assign temizle = temizle_i;
    // Responses owed to fetches issued before a flush are dropped on arrival.
    assign at      = bel_yanit_gecerli_i & (atilacak_q != '0);
`else
    assign temizle = 1'b0;
`endif

    assign kredi_var  = (bekleyen_q < DERINLIK_S);
    // bekleyen = queued + in flight, so a surplus over occupancy means some
    // fetch still owes a response; anything else arriving is stray.
    assign ucusta_var = (bekleyen_q > doluluk);

    assign bel_istek_adres_o   = cek_istek_adres_i;
    assign bel_istek_gecerli_o = rstn_i & ~temizle & cek_istek_gecerli_i & kredi_var;
    assign cek_istek_hazir_o   = rstn_i & ~temizle & bel_istek_hazir_i & kredi_var;
    assign istek_el            = bel_istek_gecerli_o & bel_istek_hazir_i;

    assign cek_yanit_gecerli_o = rstn_i & ~temizle & ~kuyruk_bos;
    assign cek_yanit_veri_o    = bas_veri;
    assign yanit_el            = cek_yanit_gecerli_o & cek_yanit_hazir_i;

    assign varis = bel_yanit_gecerli_i & ucusta_var;

`ifdef GETIR_TEMIZLE_EN
    assign yanit_yaz = rstn_i & ~temizle & varis & ~at & (~kuyruk_dolu | yanit_el);
`else
    assign yanit_yaz = rstn_i & varis & (~kuyruk_dolu | yanit_el);
`endif

    always_comb begin
        bekleyen_d = bekleyen_q + SW'(istek_el) - SW'(yanit_el);
`ifdef GETIR_TEMIZLE_EN
        atilacak_d = atilacak_q;
        if (temizle) begin
            // Whatever is still in flight after this cycle's arrival becomes
            // the discard count; queued entries vanish with the queue clear.
            atilacak_d = bekleyen_q - doluluk - SW'(varis);
            bekleyen_d = atilacak_d;
        end else if (at) begin
            atilacak_d = atilacak_q - SW'(1);
            bekleyen_d = bekleyen_q + SW'(istek_el) - SW'(yanit_el) - SW'(1);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bekleyen_q <= '0;
`ifdef GETIR_TEMIZLE_EN
            atilacak_q <= '0;
`endif
        end else begin
            bekleyen_q <= bekleyen_d;
`ifdef GETIR_TEMIZLE_EN
            atilacak_q <= atilacak_d;
`endif
        end
    end

    yanit_kuyrugu #(
        .DERINLIK (KUYRUK_DERINLIK),
        .VERI_BIT (L1_BLOK_BIT)
    ) u_yanit_kuyrugu (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .temizle_i  (temizle),
        .yaz_i      (yanit_yaz),
        .yaz_veri_i (bel_yanit_veri_i),
        .oku_i      (yanit_el),
        .bas_veri_o (bas_veri),
        .bos_o      (kuyruk_bos),
        .dolu_o     (kuyruk_dolu),
        .doluluk_o  (doluluk)
    );

endmodule

// File: tb/tb_buyruk_getir_arabirimi.sv
// ----------------------------------------------------------------------------
// tb_buyruk_getir_arabirimi
//   Self-checking bench: a hand-derived vector table, directed sequences for
//   the in-order stream, credit limit, reset and (GETIR_TEMIZLE_EN) flush,
//   then randomized traffic against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_buyruk_getir_arabirimi;
    import buyruk_getir_arabirimi_pkg::*;

    localparam int D = int'(GETIR_KUYRUK_DERINLIK);

    logic                   clk = 1'b0;
    logic                   rstn_i;
    logic [ADRES_BIT-1:0]   cek_istek_adres_i;
    logic                   cek_istek_gecerli_i;
    logic                   cek_istek_hazir_o;
    logic [L1_BLOK_BIT-1:0] cek_yanit_veri_o;
    logic                   cek_yanit_gecerli_o;
    logic                   cek_yanit_hazir_i;
    logic [ADRES_BIT-1:0]   bel_istek_adres_o;
    logic                   bel_istek_gecerli_o;
    logic                   bel_istek_hazir_i;
    logic [L1_BLOK_BIT-1:0] bel_yanit_veri_i;
    logic                   bel_yanit_gecerli_i;
    logic                   temizle_tb;

    always #5 clk = ~clk;

    buyruk_getir_arabirimi #(
        .KUYRUK_DERINLIK (D)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn_i),
        .cek_istek_adres_i   (cek_istek_adres_i),
        .cek_istek_gecerli_i (cek_istek_gecerli_i),
        .cek_istek_hazir_o   (cek_istek_hazir_o),
        .cek_yanit_veri_o    (cek_yanit_veri_o),
        .cek_yanit_gecerli_o (cek_yanit_gecerli_o),
        .cek_yanit_hazir_i   (cek_yanit_hazir_i),
        .bel_istek_adres_o   (bel_istek_adres_o),
        .bel_istek_gecerli_o (bel_istek_gecerli_o),
        .bel_istek_hazir_i   (bel_istek_hazir_i),
        .bel_yanit_veri_i    (bel_yanit_veri_i),
`ifdef GETIR_TEMIZLE_EN
        .temizle_i           (temizle_tb),
`endif
        .bel_yanit_gecerli_i (bel_yanit_gecerli_i)
    );

    int unsigned gecen  = 0;
    int unsigned toplam = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        toplam++;
        if (gercek === beklenen) gecen++;
        else $display("FAIL %s: actual=%h required=%h", ad, gercek, beklenen);
    endtask

    // Instruction memory contents for the first directed stream.
    logic [31:0] son_bes [5] = '{32'h00200113, 32'h00300193, 32'h00400213,
                                 32'h00500293, 32'h00318333};

    function automatic logic [31:0] veri_f(input logic [31:0] a);
        if (a == 32'h1000) return 32'hDEADBEEF;
        if (a < 32'h14) return 32'h00108093;
        if (a < 32'h28) return son_bes[(a >> 2) - 5];
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    // Reference model: fetches owed, fetches in flight, discards pending,
    // and the data the core should see in order.
    int          m_bekleyen;
    int          m_ucusta;
    int          m_atilacak;
    logic [31:0] m_kuyruk [$];

    // Memory model: accepted requests return in order, no earlier than 1 cycle.
    typedef struct {
        logic [31:0] veri;
        int          hazir_cyc;
    } bel_t;
    bel_t        bel_q [$];
    int          cyc = 0;
    logic [31:0] teslim_log [$];
    logic [31:0] gonderilen [$];
    int          kabul_say;

    task automatic adim(input logic iv, input logic [31:0] ia, input logic yh,
                        input logic mh, input logic men, input logic tz,
                        input logic rn, input string et);
        logic        resp;
        logic [31:0] rd;
        logic        tz_e;
        logic        e_hazir, e_belv, e_yv, req, pop;
        resp = 1'b0;
        rd   = '0;
        if (men && bel_q.size() > 0) begin
            if (bel_q[0].hazir_cyc <= cyc) begin
                resp = 1'b1;
                rd   = bel_q[0].veri;
            end
        end
`ifdef GETIR_TEMIZLE_EN
        tz_e = tz;
`else
        tz_e = 1'b0;
`endif
        cek_istek_gecerli_i = iv;
        cek_istek_adres_i   = ia;
        cek_yanit_hazir_i   = yh;
        bel_istek_hazir_i   = mh;
        bel_yanit_gecerli_i = resp;
        bel_yanit_veri_i    = rd;
        temizle_tb          = tz;
        rstn_i              = rn;
        #2;
        e_hazir = rn && !tz_e && mh && (m_bekleyen < D);
        e_belv  = rn && !tz_e && iv && (m_bekleyen < D);
        e_yv    = rn && !tz_e && (m_kuyruk.size() > 0);
        kontrol({et, "/cek_hazir"}, 32'(cek_istek_hazir_o), 32'(e_hazir));
        kontrol({et, "/bel_gecerli"}, 32'(bel_istek_gecerli_o), 32'(e_belv));
        kontrol({et, "/yanit_gecerli"}, 32'(cek_yanit_gecerli_o), 32'(e_yv));
        if (e_yv) kontrol({et, "/yanit_veri"}, cek_yanit_veri_o, m_kuyruk[0]);
        if (e_belv) kontrol({et, "/bel_adres"}, bel_istek_adres_o, ia);
        req = e_hazir && iv;
        pop = e_yv && yh;
        if (!rn) begin
            m_bekleyen = 0;
            m_ucusta   = 0;
            m_atilacak = 0;
            m_kuyruk.delete();
        end else if (tz_e) begin
            m_kuyruk.delete();
            if (resp && m_ucusta > 0) m_ucusta--;
            m_atilacak = m_ucusta;
            m_bekleyen = m_ucusta;
        end else begin
            if (pop) begin
                teslim_log.push_back(cek_yanit_veri_o);
                void'(m_kuyruk.pop_front());
                m_bekleyen--;
            end
            if (resp) begin
                if (m_atilacak > 0) begin
                    m_atilacak--;
                    m_ucusta--;
                    m_bekleyen--;
                end else if (m_ucusta > 0) begin
                    m_kuyruk.push_back(rd);
                    m_ucusta--;
                end
            end
            if (req) begin
                m_bekleyen++;
                m_ucusta++;
            end
        end
        if (resp) void'(bel_q.pop_front());
        if (req) begin
            bel_q.push_back('{veri: veri_f(ia), hazir_cyc: cyc + 1});
            gonderilen.push_back(ia);
            kabul_say++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bosta(input int n, input logic men);
        for (int i = 0; i < n; i++) adim(1'b0, 32'h0, 1'b1, 1'b1, men, 1'b0, 1'b1, "bosta");
    endtask

    task automatic sifirla();
        adim(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        teslim_log.delete();
        gonderilen.delete();
        kabul_say = 0;
    endtask

    typedef struct {
        logic        iv;
        logic        yh;
        logic        mh;
        logic        mr;
        logic [31:0] mv;
        logic        e_hazir;
        logic        e_belv;
        logic        e_yv;
        logic [31:0] e_veri;
    } vek_t;
    vek_t tablo [14];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv    yh    mh    mr    data          hazir belv  yv    head
        tablo[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        tablo[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hA1A10001, 1'b0, 1'b1, 1'b0, 32'h0};
        tablo[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA1A10001};
        tablo[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA1A10001};
        tablo[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        tablo[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hB2B20002, 1'b1, 1'b1, 1'b0, 32'h0};
        tablo[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC3C30003, 1'b1, 1'b1, 1'b1, 32'hB2B20002};
        tablo[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hB2B20002};
        tablo[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hD4D40004, 1'b0, 1'b0, 1'b1, 32'hB2B20002};
        tablo[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hE5E50005, 1'b1, 1'b0, 1'b1, 32'hC3C30003};
        tablo[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hD4D40004};
        tablo[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hE5E50005};
        tablo[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hF6F60006, 1'b1, 1'b0, 1'b0, 32'h0};
        tablo[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};

        kabul_say = 0;
        m_bekleyen = 0;
        m_ucusta = 0;
        m_atilacak = 0;
        sifirla();
        sifirla();

        // Vector table (stray response in row 12 must be ignored).
        for (int i = 0; i < 14; i++) begin
            cek_istek_gecerli_i = tablo[i].iv;
            cek_istek_adres_i   = 32'h100 + 32'(i) * 4;
            cek_yanit_hazir_i   = tablo[i].yh;
            bel_istek_hazir_i   = tablo[i].mh;
            bel_yanit_gecerli_i = tablo[i].mr;
            bel_yanit_veri_i    = tablo[i].mv;
            temizle_tb          = 1'b0;
            rstn_i              = 1'b1;
            #2;
            kontrol($sformatf("tablo%0d/cek_hazir", i), 32'(cek_istek_hazir_o), 32'(tablo[i].e_hazir));
            kontrol($sformatf("tablo%0d/bel_gecerli", i), 32'(bel_istek_gecerli_o), 32'(tablo[i].e_belv));
            kontrol($sformatf("tablo%0d/yanit_gecerli", i), 32'(cek_yanit_gecerli_o), 32'(tablo[i].e_yv));
            if (tablo[i].e_yv)
                kontrol($sformatf("tablo%0d/yanit_veri", i), cek_yanit_veri_o, tablo[i].e_veri);
            @(posedge clk);
            #1;
            cyc++;
        end
        sifirla();

        // In-order stream: 10 fetches, 1-cycle memory, core always ready.
        for (int i = 0; i < 10; i++)
            adim(1'b1, 32'(i) * 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "akis");
        bosta(4, 1'b1);
        kontrol("akis/adet", 32'(teslim_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < teslim_log.size())
                kontrol($sformatf("akis/sira%0d", i), teslim_log[i],
                        (i < 5) ? 32'h00108093 : son_bes[i - 5]);
        end

        // Credit limit: core stalls, exactly D fetches accepted.
        sifirla();
        for (int i = 0; i < 8; i++)
            adim(1'b1, 32'h3000 + 32'(i) * 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "kredi");
        kontrol("kredi/kabul", 32'(kabul_say), 32'(D));
        kontrol("kredi/hazir_kapali", 32'(cek_istek_hazir_o), 32'd0);
        for (int i = 0; i < 6; i++)
            adim(1'b1, 32'h3100 + 32'(i) * 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "serbest");
        // Sustained full-credit streaming with pushes and pops together.
        for (int i = 0; i < 12; i++)
            adim(1'b1, 32'h3200 + 32'(i) * 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "dolu_akis");
        bosta(8, 1'b1);
        kontrol("dolu_akis/adet", 32'(teslim_log.size()), 32'(gonderilen.size()));
        for (int k = 0; k < teslim_log.size(); k++)
            if (k < gonderilen.size())
                kontrol($sformatf("dolu_akis/sira%0d", k), teslim_log[k], veri_f(gonderilen[k]));

        // Reset with 2 queued and 2 in flight; late responses must not appear.
        sifirla();
        adim(1'b1, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "rst_hazirlik");
        adim(1'b1, 32'h4004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "rst_hazirlik");
        adim(1'b1, 32'h4008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "rst_hazirlik");
        adim(1'b1, 32'h400C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_hazirlik");
        adim(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_hazirlik");
        kontrol("rst/oncesi_bekleyen", 32'(cek_yanit_gecerli_o), 32'd1);
        adim(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_aktif");
        teslim_log.delete();
        adim(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "rst_sonrasi");
        adim(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "rst_gec");
        bosta(3, 1'b1);
        kontrol("rst/gec_teslim", 32'(teslim_log.size()), 32'd0);
        kontrol("rst/bel_bos", 32'(bel_q.size()), 32'd0);

`ifdef GETIR_TEMIZLE_EN
        // Flush with 2 queued and 2 in flight.
        sifirla();
        adim(1'b1, 32'h5000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "tmz_hazirlik");
        adim(1'b1, 32'h5004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "tmz_hazirlik");
        adim(1'b1, 32'h5008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "tmz_hazirlik");
        adim(1'b1, 32'h500C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "tmz_hazirlik");
        teslim_log.delete();
        adim(1'b1, 32'h5010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "tmz_darbe");
        kontrol("tmz/kuyruk_bos", 32'(cek_yanit_gecerli_o), 32'd0);
        adim(1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "tmz_yeni");
        bosta(6, 1'b1);
        kontrol("tmz/adet", 32'(teslim_log.size()), 32'd1);
        if (teslim_log.size() > 0) kontrol("tmz/deadbeef", teslim_log[0], 32'hDEADBEEF);
`endif

        // Randomized traffic against the reference model.
        sifirla();
        for (int i = 0; i < 1500; i++) begin
            logic rn_r;
            logic tz_r;
            rn_r = ($urandom_range(0, 299) != 0);
            tz_r = ($urandom_range(0, 79) == 0);
            adim($urandom_range(0, 3) != 0,
                 32'h2000 + (32'($urandom_range(0, 4095)) << 2),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 7,
                 tz_r, rn_r, "rastgele");
        end
        bosta(20, 1'b1);
        kontrol("rastgele/bos_son", 32'(cek_yanit_gecerli_o), 32'd0);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
